// File: rtl/image_pkg.sv
// Shared image-pipeline types and default geometry for the window and Sobel stages.
package image_pkg;

   localparam int DEF_PIX_W      = 4;
   localparam int DEF_IMG_WIDTH  = 160;
   localparam int DEF_IMG_HEIGHT = 120;

   typedef logic [DEF_PIX_W-1:0] pixel_t;

   // window[r][c]: r=0 is the oldest (top) row, c=0 the oldest (leftmost) column
   typedef pixel_t window_t [3][3];

endpackage

// File: rtl/window_line_buffer.sv
// One line of pixel storage, addressed by column, with read-before-write behaviour.
module window_line_buffer
   import image_pkg::*;
#(
   parameter int DEPTH  = DEF_IMG_WIDTH,
   parameter int DATA_W = DEF_PIX_W,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              writeEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData
);

   logic [DATA_W-1:0] mem [DEPTH];

   // The read is combinational, so in a write cycle it returns the value stored before the edge.
   assign readData = mem[addr];

   // Contents need no reset: the generator's valid logic never exposes a slot before it is written.
   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem[addr] <= writeData;
      end
   end

endmodule

// File: rtl/window_generator.sv
// Raster-to-3x3 window stage: two line buffers, a 3-column shift register and valid/last tagging.
module window_generator
   import image_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int PIX_W      = DEF_PIX_W
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [PIX_W-1:0] pixelIn,
   input  logic             pixelValid,
   input  logic             frameStart,
   output logic [PIX_W-1:0] window [3][3],
   output logic             windowValid,
   output logic             windowLast
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] curCol;
   logic [ROW_W-1:0] curRow;
   logic [COL_W-1:0] nextCol;
   logic [ROW_W-1:0] nextRow;
   logic             colAtEnd;
   logic             rowAtEnd;
   logic             winEligible;
   logic             winIsLast;

   logic [PIX_W-1:0] topPix;
   logic [PIX_W-1:0] midPix;

   // Resolve the accepted pixel's coordinates (frameStart forces the origin) and the advanced position.
   always_comb begin
      curCol      = frameStart ? '0 : col;
      curRow      = frameStart ? '0 : row;
      colAtEnd    = (curCol == LAST_COL);
      rowAtEnd    = (curRow == LAST_ROW);
      nextCol     = colAtEnd ? '0 : curCol + COL_W'(1);
      nextRow     = curRow;
      if (colAtEnd) begin
         nextRow = rowAtEnd ? '0 : curRow + ROW_W'(1);
      end
      winEligible = (curRow >= ROW_W'(2)) && (curCol >= COL_W'(2));
      winIsLast   = rowAtEnd && colAtEnd;
   end

   // Raster position advances only on an accepted pixel; gaps leave it untouched.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         col <= '0;
         row <= '0;
      end else if (pixelValid) begin
         col <= nextCol;
         row <= nextRow;
      end
   end

   // lineA holds the previous row and feeds lineB, which therefore holds the row before that.
   window_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (PIX_W)
   ) lineA (
      .clk       (clk),
      .writeEn   (pixelValid),
      .addr      (curCol),
      .writeData (pixelIn),
      .readData  (midPix)
   );

   window_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (PIX_W)
   ) lineB (
      .clk       (clk),
      .writeEn   (pixelValid),
      .addr      (curCol),
      .writeData (midPix),
      .readData  (topPix)
   );

   // Shift the 3x3 neighbourhood one column left and load the new vertical slice on the right.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               window[r][c] <= '0;
            end
         end
      end else if (pixelValid) begin
         for (int r = 0; r < 3; r++) begin
            window[r][0] <= window[r][1];
            window[r][1] <= window[r][2];
         end
         window[0][2] <= topPix;
         window[1][2] <= midPix;
         window[2][2] <= pixelIn;
      end
   end

   // Flag windows lying fully inside the frame; stale columns after a line wrap fail the col test.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         windowValid <= 1'b0;
         windowLast  <= 1'b0;
      end else begin
         windowValid <= pixelValid && winEligible;
         windowLast  <= pixelValid && winIsLast;
      end
   end

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator on a 4x4 frame where each pixel value is row*4+col.
module tb_window_generator;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 4;

   logic          clk;
   logic          nreset;
   logic [PW-1:0] pixelIn;
   logic          pixelValid;
   logic          frameStart;
   logic [PW-1:0] window [3][3];
   logic          windowValid;
   logic          windowLast;

   int checkCount = 0;
   int errorCount = 0;
   int pulseCount = 0;

   window_generator #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_W      (PW)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .pixelIn     (pixelIn),
      .pixelValid  (pixelValid),
      .frameStart  (frameStart),
      .window      (window),
      .windowValid (windowValid),
      .windowLast  (windowLast)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flatten the DUT window, top-left in the most significant nibble.
   function automatic logic [35:0] packWindow();
      logic [35:0] packed_w;
      packed_w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            packed_w[(8 - (r * 3 + c)) * 4 +: 4] = window[r][c];
         end
      end
      return packed_w;
   endfunction

   // Neighbourhood centred on (rc,cc) of the row*4+col test image, same packing as packWindow.
   function automatic logic [35:0] modelWindow(input int rc, input int cc);
      logic [35:0] packed_w;
      packed_w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            packed_w[(8 - (r * 3 + c)) * 4 +: 4] = 4'((rc - 1 + r) * 4 + (cc - 1 + c));
         end
      end
      return packed_w;
   endfunction

   // Drive one cycle of inputs at the falling edge, then settle just past the following rising edge.
   task automatic applyStimulus(input logic [PW-1:0] pix, input logic valid, input logic fs);
      @(negedge clk);
      pixelIn    = pix;
      pixelValid = valid;
      frameStart = fs;
      @(posedge clk);
      #1;
      if (windowValid === 1'b1) pulseCount++;
   endtask

   // Compare strobes and, when requested, the window contents against bench-computed values.
   task automatic checkOutput(input string tag, input logic expValid, input logic expLast,
                              input logic checkWin, input logic [35:0] expWin);
      logic [35:0] obsWin;
      checkCount++;
      assert (windowValid === expValid) else begin
         errorCount++;
         $error("FAIL %s windowValid: observed %b expected %b", tag, windowValid, expValid);
      end
      checkCount++;
      assert (windowLast === expLast) else begin
         errorCount++;
         $error("FAIL %s windowLast: observed %b expected %b", tag, windowLast, expLast);
      end
      if (checkWin) begin
         obsWin = packWindow();
         checkCount++;
         assert (obsWin === expWin) else begin
            errorCount++;
            $error("FAIL %s window: observed %h expected %h", tag, obsWin, expWin);
         end
      end
   endtask

   // Stream the first count pixels of a frame with gap idle cycles after each; idle cycles
   // carry frameStart=1 to show it is ignored without pixelValid.
   task automatic streamPixels(input int count, input int gap, input logic fsFirst, input string tag);
      int r;
      int c;
      logic elig;
      pulseCount = 0;
      for (int i = 0; i < count; i++) begin
         r = i / W;
         c = i % W;
         elig = (r >= 2) && (c >= 2);
         applyStimulus(PW'(r * W + c), 1'b1, fsFirst && (i == 0));
         checkOutput($sformatf("%s px(%0d,%0d)", tag, r, c), elig,
                     (r == H - 1) && (c == W - 1), elig, modelWindow(r - 1, c - 1));
         for (int g = 0; g < gap; g++) begin
            applyStimulus(4'hF, 1'b0, 1'b1);
            checkOutput($sformatf("%s gap(%0d,%0d)", tag, r, c), 1'b0, 1'b0,
                        elig, modelWindow(r - 1, c - 1));
         end
      end
   endtask

   // A full frame must yield exactly (H-2)*(W-2) single-cycle windows.
   task automatic runFrame(input int gap, input logic fsFirst, input string tag);
      streamPixels(W * H, gap, fsFirst, tag);
      checkCount++;
      assert (pulseCount === 4) else begin
         errorCount++;
         $error("FAIL %s pulses: observed %0d expected %0d", tag, pulseCount, 4);
      end
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      nreset     = 1'b0;
      pixelIn    = '0;
      pixelValid = 1'b0;
      frameStart = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 1'b0, 1'b0, 1'b1, 36'h0);
      @(negedge clk);
      nreset = 1'b1;

      $display("[TB] full frame, continuous stream");
      runFrame(0, 1'b1, "frame1");

      $display("[TB] full frame, 3-cycle gaps");
      runFrame(3, 1'b1, "gapped");

      $display("[TB] frameStart reasserted at (2,1)");
      streamPixels(9, 0, 1'b1, "abandon");
      runFrame(0, 1'b1, "restart");

      $display("[TB] asynchronous reset at (2,3)");
      streamPixels(11, 0, 1'b1, "prereset");
      applyStimulus(PW'(11), 1'b1, 1'b0);
      checkOutput("px(2,3)", 1'b1, 1'b0, 1'b1, modelWindow(1, 2));
      #1;
      nreset = 1'b0;
      #1;
      checkOutput("midreset", 1'b0, 1'b0, 1'b1, 36'h0);
      @(negedge clk);
      pixelValid = 1'b0;
      frameStart = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      runFrame(0, 1'b0, "postreset");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
